// File: rtl/digdug_vid_pkg.sv
// ---------------------------------------------------------------------------
// digdug_vid_pkg
// Shared definitions for the Dig Dug video-RAM arbiters (foreground scan VRAM
// and the sprite-attribute sibling).
//   VRAM_AW / VRAM_DW : default VRAM geometry (1K x 8)
//   SLOT_VID_ISSUE    : slot in which the video address is on the RAM port
//   SLOT_VID_CAP      : slot in which the video read data is on RAM_DO
//   vram_state_e      : arbiter FSM states
//   slot_is_cpu()     : true for slots the CPU may use
// ---------------------------------------------------------------------------
package digdug_vid_pkg;

    localparam int VRAM_AW = 10;
    localparam int VRAM_DW = 8;

    localparam logic [2:0] SLOT_VID_ISSUE = 3'd0;
    localparam logic [2:0] SLOT_VID_CAP   = 3'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        WR    = 3'd3,
        CLEAR = 3'd4
    } vram_state_e;

    function automatic logic slot_is_cpu(input logic [2:0] slot);
        return (slot != SLOT_VID_ISSUE) && (slot != SLOT_VID_CAP);
    endfunction

endpackage

// File: rtl/digdug_slot_gen.sv
// ---------------------------------------------------------------------------
// digdug_slot_gen
// Free-running 3-bit slot counter (one VCLK period = 8 master cycles) plus the
// decodes the arbiters need to register RAM-port values into the next slot.
// Ports:
//   i_clk            master clock
//   i_rst            asynchronous active-high reset (slot restarts at 0)
//   o_slot           current slot number
//   o_next_vid_issue next slot is the video issue slot
//   o_cur_vid_cap    current slot is the video capture slot
//   o_next_cpu       next slot is CPU-eligible
// ---------------------------------------------------------------------------
module digdug_slot_gen
    import digdug_vid_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [2:0] o_slot,
    output logic       o_next_vid_issue,
    output logic       o_cur_vid_cap,
    output logic       o_next_cpu
);

    logic [2:0] r_slot;
    logic [2:0] w_next_slot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= 3'd0;
        end else begin
            r_slot <= w_next_slot;
        end
    end

    // Wraps 7 -> 0 naturally in 3 bits.
    assign w_next_slot      = r_slot + 3'd1;
    assign o_slot           = r_slot;
    assign o_next_vid_issue = (w_next_slot == SLOT_VID_ISSUE);
    assign o_cur_vid_cap    = (r_slot == SLOT_VID_CAP);
    assign o_next_cpu       = slot_is_cpu(w_next_slot);

endmodule

// File: rtl/digdug_vram_arbiter.sv
// ---------------------------------------------------------------------------
// digdug_vram_arbiter
// Time-slot arbiter for the 1K x 8 foreground scan VRAM. Owns the single
// synchronous-read RAM port: slot 0 carries the video scan address, slot 1
// returns its data, slots 2..7 serve the CPU.
//
// Optional feature (macro DIGDUG_VRAM_CLEAR_EN): after reset the FSM walks
// every address writing CLEAR_VAL, one write per CPU slot, stalling the CPU.
//
// Ports:
//   CLK48M, RESET       master clock, async active-high reset
//   VID_AD / VID_DT     video scan address in / registered scan data out
//   CPU_REQ/WE/AD/DI    CPU request, direction, address, write data
//   CPU_DO / CPU_ACK    CPU read data / one-cycle completion pulse
//   CPU_WAIT            combinational Z80 WAIT
//   RAM_AD/WE/DI/DO     registered RAM port, RAM_DO valid one cycle later
//   SLOT                current slot number
//   DBG_STATE           current FSM state (debug visibility)
//
// CPU handshake: CPU_REQ is a level held (with WE/AD/DI stable) until the
// cycle CPU_ACK is high. The request is accepted in a cycle whose next slot is
// CPU-eligible; ACK is never raised without a prior accept. A REQ still high
// in the cycle after ACK is a new transaction. CPU_WAIT = REQ & ~ACK & ~accept.
// ---------------------------------------------------------------------------
module digdug_vram_arbiter
    import digdug_vid_pkg::*;
#(
    parameter int            AW        = VRAM_AW,
    parameter int            DW        = VRAM_DW,
    parameter logic [DW-1:0] CLEAR_VAL = 8'h00
) (
    input  logic          CLK48M,
    input  logic          RESET,
    input  logic [AW-1:0] VID_AD,
    output logic [DW-1:0] VID_DT,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_AD,
    input  logic [DW-1:0] CPU_DI,
    output logic [DW-1:0] CPU_DO,
    output logic          CPU_ACK,
    output logic          CPU_WAIT,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO,
    output logic [2:0]    SLOT,
    output vram_state_e   DBG_STATE
);

`ifdef DIGDUG_VRAM_CLEAR_EN
    localparam vram_state_e RST_STATE = CLEAR;
`else
    localparam vram_state_e RST_STATE = IDLE;
`endif

    logic [2:0]    w_slot;
    logic          w_next_vid_issue;
    logic          w_cur_vid_cap;
    logic          w_next_cpu;

    vram_state_e   r_state;
    vram_state_e   w_state_nxt;

    logic [AW-1:0] r_ram_ad;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_di;
    logic [DW-1:0] r_vid_dt;
    logic [DW-1:0] r_cpu_do;
    logic          r_cpu_ack;

    logic          w_accept;
    logic          w_clr_wr;
    logic          w_clr_last;
    logic [AW-1:0] w_clr_ad;

    digdug_slot_gen u_slot_gen (
        .i_clk            (CLK48M),
        .i_rst            (RESET),
        .o_slot           (w_slot),
        .o_next_vid_issue (w_next_vid_issue),
        .o_cur_vid_cap    (w_cur_vid_cap),
        .o_next_cpu       (w_next_cpu)
    );

    // The ACK cycle still carries the old request, so it must not be taken
    // as a new one.
    assign w_accept = (r_state == IDLE) && CPU_REQ && !r_cpu_ack && w_next_cpu;

`ifdef DIGDUG_VRAM_CLEAR_EN
    logic [AW-1:0] r_clr_ad;

    assign w_clr_wr   = (r_state == CLEAR) && w_next_cpu;
    assign w_clr_last = &r_clr_ad;
    assign w_clr_ad   = r_clr_ad;

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            r_clr_ad <= '0;
        end else if (w_clr_wr) begin
            r_clr_ad <= r_clr_ad + {{(AW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign w_clr_wr   = 1'b0;
    assign w_clr_last = 1'b0;
    assign w_clr_ad   = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CPU_WE ? WR : RD;
            RD:      w_state_nxt = CAP;
            CAP:     w_state_nxt = IDLE;
            WR:      w_state_nxt = IDLE;
            CLEAR:   if (w_clr_wr && w_clr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- RAM port ----------------
    // Values are registered into the slot they belong to, so every decision
    // here looks at the *next* slot. RAM_WE is a one-slot strobe.
    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            r_ram_ad <= '0;
            r_ram_we <= 1'b0;
            r_ram_di <= '0;
        end else if (w_next_vid_issue) begin
            r_ram_ad <= VID_AD;
            r_ram_we <= 1'b0;
        end else if (w_accept || w_clr_wr) begin
            r_ram_ad <= w_clr_wr ? w_clr_ad : CPU_AD;
            r_ram_we <= w_clr_wr | CPU_WE;
            r_ram_di <= w_clr_wr ? CLEAR_VAL : CPU_DI;
        end else begin
            r_ram_we <= 1'b0;
        end
    end

    // ---------------- read data / completion ----------------
    // A read issued in slot 7 captures in slot 0; the slot-0 video address
    // only reaches RAM_DO in slot 1, so the two never collide.
    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            r_vid_dt  <= '0;
            r_cpu_do  <= '0;
            r_cpu_ack <= 1'b0;
        end else begin
            if (w_cur_vid_cap) begin
                r_vid_dt <= RAM_DO;
            end
            if (r_state == CAP) begin
                r_cpu_do <= RAM_DO;
            end
            r_cpu_ack <= (r_state == WR) || (r_state == CAP);
        end
    end

    assign RAM_AD    = r_ram_ad;
    assign RAM_WE    = r_ram_we;
    assign RAM_DI    = r_ram_di;
    assign VID_DT    = r_vid_dt;
    assign CPU_DO    = r_cpu_do;
    assign CPU_ACK   = r_cpu_ack;
    assign CPU_WAIT  = CPU_REQ && !r_cpu_ack && !w_accept;
    assign SLOT      = w_slot;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_digdug_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_digdug_vram_arbiter
// Bench for digdug_vram_arbiter with a behavioural 1K x 8 sync-read RAM.
// Handles both builds (with or without DIGDUG_VRAM_CLEAR_EN).
// ---------------------------------------------------------------------------
module tb_digdug_vram_arbiter;
    import digdug_vid_pkg::*;

    localparam logic [7:0] CLR_V = 8'h24;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        RESET;
    logic [9:0]  VID_AD;
    logic [7:0]  VID_DT;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [9:0]  CPU_AD;
    logic [7:0]  CPU_DI;
    logic [7:0]  CPU_DO;
    logic        CPU_ACK;
    logic        CPU_WAIT;
    logic [9:0]  RAM_AD;
    logic        RAM_WE;
    logic [7:0]  RAM_DI;
    logic [7:0]  RAM_DO;
    logic [2:0]  SLOT;
    vram_state_e DBG_STATE;

    always #5 clk = ~clk;

    digdug_vram_arbiter #(.AW(10), .DW(8), .CLEAR_VAL(CLR_V)) dut (
        .CLK48M    (clk),
        .RESET     (RESET),
        .VID_AD    (VID_AD),
        .VID_DT    (VID_DT),
        .CPU_REQ   (CPU_REQ),
        .CPU_WE    (CPU_WE),
        .CPU_AD    (CPU_AD),
        .CPU_DI    (CPU_DI),
        .CPU_DO    (CPU_DO),
        .CPU_ACK   (CPU_ACK),
        .CPU_WAIT  (CPU_WAIT),
        .RAM_AD    (RAM_AD),
        .RAM_WE    (RAM_WE),
        .RAM_DI    (RAM_DI),
        .RAM_DO    (RAM_DO),
        .SLOT      (SLOT),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- RAM macro model ----------------
    logic [7:0] mem [1024];

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] <= 8'(k);
        forever begin
            @(posedge clk);
            if (RAM_WE) mem[RAM_AD] <= RAM_DI;
            RAM_DO <= mem[RAM_AD];
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0] ref_mem [1024];
    int         cyc;
    logic [2:0] tslot;

    // Cycles since reset release; the slot is simply that count mod 8.
    always @(posedge clk or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end
    assign tslot = 3'(cyc % 8);

    function automatic logic [7:0] pre_val(input logic [9:0] a);
`ifdef DIGDUG_VRAM_CLEAR_EN
        return CLR_V;
`else
        return a[7:0];
`endif
    endfunction

    // Cycles a request raised in slot s waits before it is accepted: it is
    // taken in the first cycle whose following slot is one of 2..7.
    function automatic int model_delay(input int s);
        int d;
        d = 0;
        while (!(((s + d) % 8) >= 1 && ((s + d) % 8) <= 6)) d++;
        return d;
    endfunction

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         vid_mon_en = 1'b0;
    bit         mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Video expectation: address seen entering slot 0, data visible in slot 2.
    always @(posedge clk) begin
        if (!RESET && vid_mon_en && tslot == 3'd7) exp_q.push_back(ref_mem[VID_AD]);
    end

    always @(negedge clk) begin
        if (!RESET && vid_mon_en && tslot == 3'd2 && exp_q.size() > 0)
            check("vid_dt", {24'd0, VID_DT}, {24'd0, exp_q.pop_front()});
    end

    always @(posedge RESET) exp_q.delete();

    always @(negedge clk) begin
        if (!RESET && mon_en) begin
            check("slot", {29'd0, SLOT}, {29'd0, tslot});
            if (RAM_WE) check("ram_we_cpu_slot", {31'd0, (tslot >= 3'd2)}, 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_slot(input logic [2:0] s);
        @(negedge clk);
        for (int k = 0; k < 16 && tslot != s; k++) @(negedge clk);
    endtask

    // Called just after a negedge; returns in the ACK cycle (or on timeout).
    task automatic cpu_txn(input logic we, input logic [9:0] ad, input logic [7:0] di,
                           input bit hold, output int lat, output int waits,
                           output logic [7:0] rd);
        lat   = -1;
        waits = 0;
        rd    = 8'h00;
        CPU_REQ = 1'b1;
        CPU_WE  = we;
        CPU_AD  = ad;
        CPU_DI  = di;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (CPU_ACK) begin
                lat = c;
                rd  = CPU_DO;
                break;
            end
            if (CPU_WAIT) waits++;
            @(negedge clk);
        end
        if (!hold) CPU_REQ = 1'b0;
    endtask

    task automatic wait_clear_done();
        for (int k = 0; k < 1500 && DBG_STATE == CLEAR; k++) @(negedge clk);
        for (int k = 0; k < 1024; k++) ref_mem[k] = CLR_V;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0] slot;
        logic       we;
        logic [9:0] ad;
        logic [7:0] di;
        logic [9:0] vid;
        int         lat;
        int         waits;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         waits;
        int         s;
        int         d;
        int         acks;
        int         bad;
        int         clr_done;
        bit         found;
        logic       we;
        logic [9:0] ad;
        logic [7:0] di;
        logic [7:0] rd;

        vecs[0] = '{3'd3, 1'b1, 10'h020, 8'hA7, 10'h155, 2, 1, 8'h00};
        vecs[1] = '{3'd3, 1'b0, 10'h020, 8'h00, 10'h155, 3, 2, 8'hA7};
        vecs[2] = '{3'd7, 1'b0, 10'h3FF, 8'h00, 10'h155, 5, 4, pre_val(10'h3FF)};
        vecs[3] = '{3'd6, 1'b0, 10'h010, 8'h00, 10'h011, 3, 2, pre_val(10'h010)};
        vecs[4] = '{3'd0, 1'b1, 10'h300, 8'h5A, 10'h011, 3, 2, 8'h00};
        vecs[5] = '{3'd1, 1'b0, 10'h300, 8'h00, 10'h155, 3, 2, 8'h5A};
        vecs[6] = '{3'd5, 1'b1, 10'h3FF, 8'hC3, 10'h155, 2, 1, 8'h00};
        vecs[7] = '{3'd7, 1'b0, 10'h3FF, 8'h00, 10'h155, 5, 4, 8'hC3};
        vecs[8] = '{3'd6, 1'b1, 10'h210, 8'h3C, 10'h155, 2, 1, 8'h00};
        vecs[9] = '{3'd2, 1'b0, 10'h210, 8'h00, 10'h155, 3, 2, 8'h3C};

        for (int k = 0; k < 1024; k++) ref_mem[k] = 8'(k);

        // ---- reset ----
        RESET   = 1'b1;
        VID_AD  = 10'h155;
        CPU_REQ = 1'b0;
        CPU_WE  = 1'b0;
        CPU_AD  = '0;
        CPU_DI  = '0;
        repeat (3) @(negedge clk);
        check("rst_slot",    {29'd0, SLOT},    32'd0);
        check("rst_ram_ad",  {22'd0, RAM_AD},  32'd0);
        check("rst_ram_we",  {31'd0, RAM_WE},  32'd0);
        check("rst_ram_di",  {24'd0, RAM_DI},  32'd0);
        check("rst_vid_dt",  {24'd0, VID_DT},  32'd0);
        check("rst_cpu_do",  {24'd0, CPU_DO},  32'd0);
        check("rst_cpu_ack", {31'd0, CPU_ACK}, 32'd0);
`ifdef DIGDUG_VRAM_CLEAR_EN
        check("rst_state", {29'd0, DBG_STATE}, {29'd0, CLEAR});
`else
        check("rst_state", {29'd0, DBG_STATE}, {29'd0, IDLE});
`endif
        RESET  = 1'b0;
        mon_en = 1'b1;

`ifdef DIGDUG_VRAM_CLEAR_EN
        // ---- clear sequencer: CPU read raised at once must wait ----
        CPU_REQ  = 1'b1;
        CPU_WE   = 1'b0;
        CPU_AD   = 10'h155;
        bad      = 0;
        clr_done = -1;
        lat      = -1;
        for (int c = 0; c < 1500; c++) begin
            #1;
            if (CPU_ACK) begin
                lat = c;
                rd  = CPU_DO;
                break;
            end
            if (DBG_STATE == CLEAR && !CPU_WAIT) bad++;
            if (DBG_STATE != CLEAR && clr_done < 0) clr_done = cyc;
            @(negedge clk);
        end
        CPU_REQ = 1'b0;
        check("clear_wait_high", bad, 0);
        check("clear_done_bound", {31'd0, (clr_done >= 1024 && clr_done <= 1366)}, 32'd1);
        check("clear_ack_after", {31'd0, (lat > clr_done)}, 32'd1);
        check("clear_cpu_rd", {24'd0, rd}, {24'd0, CLR_V});
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== CLR_V) bad++;
        check("clear_all_locations", bad, 0);
        wait_clear_done();
`endif

        // ---- idle video only ----
        vid_mon_en = 1'b1;
        repeat (40) @(negedge clk);

        // ---- directed table ----
        foreach (vecs[i]) begin
            VID_AD = vecs[i].vid;
            wait_slot(vecs[i].slot);
            cpu_txn(vecs[i].we, vecs[i].ad, vecs[i].di, 1'b0, lat, waits, rd);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_wait", i), waits, vecs[i].waits);
            if (vecs[i].we) ref_mem[vecs[i].ad] = vecs[i].di;
            else check($sformatf("vec%0d_rd", i), {24'd0, rd}, {24'd0, vecs[i].rdata});
        end

        // ---- randomized transactions vs. model ----
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            ad = we ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 1023));
            di = 8'($urandom);
            if ($urandom_range(0, 3) == 0) VID_AD = 10'($urandom_range(256, 511));
            repeat ($urandom_range(1, 6)) @(negedge clk);
            s = int'(tslot);
            d = model_delay(s);
            cpu_txn(we, ad, di, 1'b0, lat, waits, rd);
            check($sformatf("rnd%0d_lat", n), lat, d + (we ? 2 : 3));
            check($sformatf("rnd%0d_wait", n), waits, d + (we ? 1 : 2));
            if (we) ref_mem[ad] = di;
            else check($sformatf("rnd%0d_rd", n), {24'd0, rd}, {24'd0, ref_mem[ad]});
        end

        // ---- back-to-back writes with REQ held ----
        wait_slot(3'd2);
        for (int i = 0; i < 4; i++) begin
            s = int'(tslot);
            d = model_delay(s);
            cpu_txn(1'b1, 10'h2A0 + 10'(i), 8'h60 + 8'(i), 1'b1, lat, waits, rd);
            check($sformatf("b2b%0d_lat", i), lat, d + 2);
            ref_mem[10'h2A0 + 10'(i)] = 8'h60 + 8'(i);
            @(negedge clk);
        end
        CPU_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_slot(3'd3);
            cpu_txn(1'b0, 10'h2A0 + 10'(i), 8'h00, 1'b0, lat, waits, rd);
            check($sformatf("b2b%0d_rd", i), {24'd0, rd}, {24'd0, 8'h60 + 8'(i)});
        end

        // ---- reset during the 3rd held write ----
        wait_slot(3'd4);
        for (int i = 0; i < 2; i++) begin
            s = int'(tslot);
            d = model_delay(s);
            cpu_txn(1'b1, 10'h2C0 + 10'(i), 8'h70 + 8'(i), 1'b1, lat, waits, rd);
            check($sformatf("rst_seq%0d_lat", i), lat, d + 2);
            ref_mem[10'h2C0 + 10'(i)] = 8'h70 + 8'(i);
            @(negedge clk);
        end
        CPU_WE = 1'b1;
        CPU_AD = 10'h3F0;
        CPU_DI = 8'hEE;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (RAM_WE && RAM_AD == 10'h3F0) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_write_started", {31'd0, found}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_mid_ram_we", {31'd0, RAM_WE}, 32'd0);
        check("rst_mid_slot", {29'd0, SLOT}, 32'd0);
        CPU_REQ = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (CPU_ACK) acks++;
        end
        RESET = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (CPU_ACK) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
`ifdef DIGDUG_VRAM_CLEAR_EN
        wait_clear_done();
`endif

        // ---- recovery after reset ----
        wait_slot(3'd2);
        cpu_txn(1'b1, 10'h250, 8'h99, 1'b0, lat, waits, rd);
        check("recover_wr_lat", lat, 2);
        wait_slot(3'd4);
        cpu_txn(1'b0, 10'h250, 8'h00, 1'b0, lat, waits, rd);
        check("recover_rd_lat", lat, 3);
        check("recover_rd", {24'd0, rd}, 32'h99);

        repeat (20) @(negedge clk);
        mon_en     = 1'b0;
        vid_mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
